// File: rtl/pulse_scheduler_pkg.sv
// rtl/pulse_scheduler_pkg.sv - shared types and helpers for the pulse scheduler
// Purpose: FSM state encoding and the round-robin index step used by the arbiter.
// Ports: none (package).
package pulse_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Next index in round-robin order, wrapping to 0 after the last channel.
    // Out-of-range indices also wrap to 0 so the arbiter always lands on a legal channel.
    function automatic int rr_next_index(input int index, input int channels);
        return (index + 1 >= channels) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first requesting channel after last_grant, wrapping around.
// Ports:
//   request     in  CHANNELS  per-channel request vector
//   last_grant  in  ID_WIDTH  index granted most recently
//   grant       out CHANNELS  one-hot grant (all zero when nothing requests)
//   grant_index out ID_WIDTH  index of the granted channel
//   grant_valid out 1         some channel is granted
module round_robin_arbiter #(
    parameter int CHANNELS = 4,
    localparam int ID_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [CHANNELS-1:0] grant,
    output logic [ID_WIDTH-1:0] grant_index,
    output logic                grant_valid
);
    import pulse_scheduler_pkg::*;

    int                candidate;
    logic [ID_WIDTH-1:0] cand_idx;

    // Walk CHANNELS positions starting just after last_grant; the first hit wins,
    // so last_grant itself is checked last.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        candidate   = int'(last_grant);
        cand_idx    = '0;
        for (int step = 0; step < CHANNELS; step++) begin
            candidate = rr_next_index(candidate, CHANNELS);
            cand_idx  = ID_WIDTH'(candidate);
            if (!grant_valid && request[cand_idx]) begin
                grant_valid     = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_index     = cand_idx;
            end
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// rtl/pulse_scheduler.sv - multi-channel pulse scheduler onto one shared pulse line
// Purpose: per-channel saturating pending counters drained round-robin as single-cycle
//          pulses separated by at least GAP_CYCLES low cycles.
// Ports:
//   clock          in  1                 single clock
//   reset          in  1                 synchronous active-high reset
//   pulse_in       in  CHANNELS          per-channel pulse requests (one per high cycle)
//   busy           out CHANNELS          counter saturated, new pulses are dropped
//   pulse_out      out 1                 registered single-cycle output pulse
//   pulse_channel  out CHANNEL_ID_WIDTH  owner of the current/last pulse_out
//   active         out 1                 pending pulses exist or FSM not idle
module pulse_scheduler #(
    parameter int CHANNELS            = 4,
    parameter int PULSE_COUNTER_WIDTH = 3,
    parameter int GAP_CYCLES          = 1,
    localparam int CHANNEL_ID_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         pulse_in,
    output logic [CHANNELS-1:0]         busy,
    output logic                        pulse_out,
    output logic [CHANNEL_ID_WIDTH-1:0] pulse_channel,
    output logic                        active
);
    import pulse_scheduler_pkg::*;

    localparam logic [PULSE_COUNTER_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [PULSE_COUNTER_WIDTH-1:0] COUNT_ONE = PULSE_COUNTER_WIDTH'(1);
    localparam int                             GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0]               GAP_LOAD  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0]               GAP_LAST  = GAP_W'(1);

    logic [CHANNELS-1:0]         accepted;
    logic [CHANNELS-1:0]         request;
    logic [CHANNELS-1:0]         count_nonzero;
    logic [CHANNELS-1:0]         grant_onehot;
    logic [CHANNEL_ID_WIDTH-1:0] grant_index;
    logic [CHANNEL_ID_WIDTH-1:0] last_grant;
    logic                        grant_valid;
    logic                        grant_window;
    logic                        grant_fire;
    state_t                      state;
    logic [GAP_W-1:0]            gap_count;

    // Grants are only taken while idle or on the final gap cycle, which is what
    // enforces the minimum spacing between output pulses.
    assign grant_window = (state == ST_IDLE) || ((state == ST_GAP) && (gap_count == GAP_LAST));
    assign grant_fire   = grant_window && grant_valid;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
            logic [PULSE_COUNTER_WIDTH-1:0] count;

            assign busy[i]          = (count == COUNT_MAX);
            assign count_nonzero[i] = (count != '0);
            assign accepted[i]      = pulse_in[i] & ~busy[i];
            // The accepted-pulse bypass lets an idle scheduler fire on the next cycle.
            assign request[i]       = count_nonzero[i] | accepted[i];

            always_ff @(posedge clock) begin
                if (reset) begin
                    count <= '0;
                end else if (grant_fire && grant_onehot[i]) begin
                    // Accepted and granted together cancel out, even at zero.
                    if (!accepted[i]) begin
                        count <= count - COUNT_ONE;
                    end
                end else if (accepted[i]) begin
                    count <= count + COUNT_ONE;
                end
            end
        end
    endgenerate

    round_robin_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .request     (request),
        .last_grant  (last_grant),
        .grant       (grant_onehot),
        .grant_index (grant_index),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            gap_count     <= '0;
            pulse_out     <= 1'b0;
            pulse_channel <= '0;
            last_grant    <= CHANNEL_ID_WIDTH'(CHANNELS - 1);
        end else begin
            pulse_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_fire) begin
                        pulse_out     <= 1'b1;
                        pulse_channel <= grant_index;
                        last_grant    <= grant_index;
                        state         <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    gap_count <= GAP_LOAD;
                    state     <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_count == GAP_LAST) begin
                        if (grant_fire) begin
                            pulse_out     <= 1'b1;
                            pulse_channel <= grant_index;
                            last_grant    <= grant_index;
                            state         <= ST_PULSE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_count <= gap_count - GAP_LAST;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign active = (|count_nonzero) | (state != ST_IDLE);

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Multi-channel pulse scheduler that merges pulse requests from several independent sources onto one shared pulse line. Each channel counts its pending pulses in a saturating counter. A round-robin arbiter drains these counters as well-separated single-cycle pulses tagged with the channel number. It sits in front of any single-pulse consumer, such as an event counter, interrupt line or credit return, that several requesters must share.

## Interface
- `CHANNELS`, default 4: number of requesting channels, minimum 1.
- `PULSE_COUNTER_WIDTH`, default 3: width of each pending counter; saturates at 2^W-1.
- `GAP_CYCLES`, default 1: minimum number of low cycles between two output pulses, minimum 1.
- `CHANNEL_ID_WIDTH`: localparam, max(1, $clog2(CHANNELS)).

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `pulse_in`, in, CHANNELS: per-channel pulse request; each high cycle is one pulse.
- `busy`, out, CHANNELS: channel counter saturated; pulses on that channel are dropped.
- `pulse_out`, out, 1: single-cycle output pulse.
- `pulse_channel`, out, CHANNEL_ID_WIDTH: channel owning the current `pulse_out`; holds its last value otherwise.
- `active`, out, 1: any counter is non-zero or the FSM is not IDLE.

## Operation
- **Accept rule:** `pulse_in[i]` is accepted iff `busy[i]` is low. An accepted pulse adds 1 to `counter[i]`. Pulses arriving while busy are lost, with no error flag.
- **Request:** `request[i] = (counter[i] != 0) | (pulse_in[i] & ~busy[i])`. The bypass gives single-cycle latency.
- **Counter update (granted channel):**
  - next = counter + accepted − 1.
  - A pulse accepted and granted in the same cycle leaves the counter unchanged, including at 0.
  - A channel that is busy and granted decrements by 1.
- **Counter update (non-granted channel):** next = counter + accepted, never exceeding 2^W-1.
- **FSM states:**
  - IDLE: `pulse_out` low. If any request is set, grant one channel and go to PULSE.
  - PULSE: `pulse_out` high for exactly one cycle. Load the gap counter with GAP_CYCLES and go to GAP.
  - GAP: `pulse_out` low. Decrement the gap counter. When it reaches 1, grant if any request is set and go to PULSE, else go to IDLE.
- **Grant timing:** grant happens only in IDLE, or on the last GAP cycle.
- **Round-robin:**
  - Priority starts at `last_grant+1` mod CHANNELS and wraps around.
  - `last_grant` updates only on a grant.
  - After reset, `last_grant` = CHANNELS-1, so channel 0 has first priority.
- **Arithmetic:** all counters are unsigned. No wrap-around is possible: increment is blocked at max, and decrement occurs only on a granted channel, whose request guarantees a non-zero effective value.

## Timing
- **Reset:** synchronous. On the cycle after `reset` is sampled high, all outputs are 0 (`busy`, `pulse_out`, `pulse_channel`, `active`), the FSM is IDLE and all counters are 0.
- **Reset mid-operation:** reset sampled mid-operation discards all pending pulses, and `pulse_out` is low on the next cycle.
- **Latency:** `pulse_in[i]` high in cycle n, with the FSM in IDLE → `pulse_out` high in cycle n+1 with `pulse_channel` = i.
- **Throughput:** at most one pulse every GAP_CYCLES+1 cycles, aggregated over all channels.
- **Registered outputs:** `pulse_out` and `pulse_channel` are registered and change only together.
- **Derived outputs:** `busy` is a registered-state decode, so it is glitch-free and has no input-to-output combinational path. `active` is the same kind of decode.
- **Simultaneous requests:** the winner is resolved by round-robin only. No channel is granted twice while another channel has a continuous request.

## Structure
- Package `pulse_scheduler_pkg` holds:
  - the FSM state enum (IDLE, PULSE, GAP);
  - a helper function for the next round-robin index.
- Sub-module `round_robin_arbiter`, parameter CHANNELS:
  - inputs: request vector and `last_grant` index;
  - outputs: one-hot grant, grant index and a `grant_valid` flag;
  - purely combinational, reusable elsewhere.
- The top level contains the per-channel counters (generate loop), the FSM, the gap counter and the output registers.

## Test plan
Use CHANNELS=4, PULSE_COUNTER_WIDTH=3, GAP_CYCLES=1 unless stated otherwise.

- Channel 2 high for one cycle n → `pulse_out` high only in cycle n+1, `pulse_channel`=2, one pulse total, `active` low from n+3.
- Channels 0 and 3 high together for one cycle n → pulses in n+1 (channel 0) and n+3 (channel 3), nothing else.
- Channel 1 held high for 4 cycles → exactly 4 pulses, channel 1, each 1 cycle wide, 1 low cycle between them.
- Channel 0 held high until `busy[0]` rises, then released → pulse count equals the number of cycles with `pulse_in[0]` & ~`busy[0]`, and `busy[0]` falls after the next drain.
- All 4 channels held high for 8 cycles → `pulse_channel` sequence 0,1,2,3,0,1,2,3,… with no channel repeating before the other three.
- Load channel 2 with 5 pending pulses, assert `reset` for one cycle mid-drain → `pulse_out` low from the next cycle, all `busy` 0, no further pulses.
